e_mdu: RTL and testbench

Multiply/divide unit sitting beside the ALU in the E stage of the five-stage MIPS pipeline. It takes the same forwarded operands as the ALU and executes mult, multu, div, divu, mthi, mtlo, mfhi and mflo. The block owns the HI/LO registers and drives a busy flag that the hazard unit uses to stall MDU-class instructions in D. Its mf result is muxed with the ALU result into the E/M pipeline register.

---
 rtl/e_mdu_pkg.sv | 19 +
 rtl/e_mdu.sv | 78 +++++++
 tb/tb_e_mdu.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg: shared MDU op encodings and default busy-cycle counts.
package e_mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit owning HI/LO; the result is computed at launch
// and held in pend registers until the down-counter expires.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDUop,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic [31:0] MDUout
);

    logic [31:0] r_hi, r_lo, r_pend_hi, r_pend_lo;
    logic [3:0]  r_cnt;
    logic        r_busy;

    mdu_op_e     w_op;
    logic        w_is_mul, w_is_div, w_launch;
    logic [63:0] w_prod_s, w_prod_u, w_pend;
    logic [31:0] w_mag_a, w_mag_b, w_qmag, w_rmag, w_quo_s, w_rem_s;

    assign w_op     = mdu_op_e'(MDUop);
    assign w_is_mul = (w_op == MDU_MULT) || (w_op == MDU_MULTU);
    assign w_is_div = (w_op == MDU_DIV) || (w_op == MDU_DIVU);
    assign w_launch = start && !r_busy && (w_is_mul || w_is_div);

    assign w_prod_s = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
    assign w_prod_u = {32'd0, srcA} * {32'd0, srcB};

    // Signed divide via magnitudes so INT_MIN/-1 wraps to 0x8000_0000 without overflow
    assign w_mag_a  = srcA[31] ? -srcA : srcA;
    assign w_mag_b  = srcB[31] ? -srcB : srcB;
    assign w_qmag   = w_mag_a / w_mag_b;
    assign w_rmag   = w_mag_a % w_mag_b;
    assign w_quo_s  = (srcA[31] ^ srcB[31]) ? -w_qmag : w_qmag;
    assign w_rem_s  = srcA[31] ? -w_rmag : w_rmag;

    assign w_pend = (w_is_div && srcB == 32'd0) ? {r_hi, r_lo} :
                    (w_op == MDU_MULT)          ? w_prod_s :
                    (w_op == MDU_MULTU)         ? w_prod_u :
                    (w_op == MDU_DIV)           ? {w_rem_s, w_quo_s} :
                                                  {srcA % srcB, srcA / srcB};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
        end else if (r_busy) begin
            if (r_cnt == 4'd1) begin
                r_hi   <= r_pend_hi;
                r_lo   <= r_pend_lo;
                r_busy <= 1'b0;
            end
            r_cnt <= r_cnt - 4'd1;
        end else if (w_launch) begin
            {r_pend_hi, r_pend_lo} <= w_pend;
            r_cnt  <= w_is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            r_busy <= 1'b1;
        end else begin
            if (w_op == MDU_MTHI) r_hi <= srcA;
            if (w_op == MDU_MTLO) r_lo <= srcA;
        end
    end

    assign busy   = r_busy;
    assign MDUout = (w_op == MDU_MFHI) ? r_hi : (w_op == MDU_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed tests of e_mdu with hand-computed HI/LO and busy-length expectations.
module tb_e_mdu;
    import e_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  MDUop = 4'd0;
    logic [31:0] srcA = '0;
    logic [31:0] srcB = '0;
    logic        busy;
    logic [31:0] MDUout;

    int checks = 0;
    int errors = 0;
    int illegal_hits = 0;

    e_mdu dut (
        .clk(clk), .reset(reset), .start(start), .MDUop(MDUop),
        .srcA(srcA), .srcB(srcB), .busy(busy), .MDUout(MDUout)
    );

    always #5 clk = ~clk;

    // Illegal-use monitor: start or mt while busy is counted for later comparison
    always @(posedge clk)
        if (reset && busy && (start || MDUop == MDU_MTHI || MDUop == MDU_MTLO))
            illegal_hits++;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Launch an op, then count busy cycles until it drops (bounded)
    task automatic run_op(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b, output int n);
        start = 1'b1; MDUop = op; srcA = a; srcB = b;
        tick();
        start = 1'b0; MDUop = MDU_NONE; srcA = '0; srcB = '0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        MDUop = MDU_MFHI; #1; hi = MDUout;
        MDUop = MDU_MFLO; #1; lo = MDUout;
        MDUop = MDU_NONE; #1;
    endtask

    task automatic write_hilo(input mdu_op_e op, input logic [31:0] v);
        MDUop = op; srcA = v;
        tick();
        MDUop = MDU_NONE; srcA = '0;
    endtask

    task automatic test_reset;
        logic [31:0] hi, lo;
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        read_hilo(hi, lo);
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
        checks++; if (MDUout !== 32'd0) begin errors++; $display("FAIL reset_mduout got %h want 0", MDUout); end
    endtask

    task automatic test_mult;
        int n;
        logic [31:0] hi, lo;
        run_op(MDU_MULT, 32'hFFFF_FFFE, 32'd3, n);
        checks++; if (n !== 5) begin errors++; $display("FAIL mult_busy got %0d want 5", n); end
        read_hilo(hi, lo);
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got %h want fffffffa", lo); end
        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        checks++; if (n !== 5) begin errors++; $display("FAIL multu_busy got %0d want 5", n); end
        read_hilo(hi, lo);
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h want 00000001", lo); end
    endtask

    task automatic test_div;
        int n;
        logic [31:0] hi, lo;
        run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, n);
        checks++; if (n !== 10) begin errors++; $display("FAIL div_busy got %0d want 10", n); end
        read_hilo(hi, lo);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", hi); end
        run_op(MDU_DIVU, 32'd7, 32'd2, n);
        read_hilo(hi, lo);
        checks++; if (lo !== 32'd3) begin errors++; $display("FAIL divu_lo got %h want 3", lo); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL divu_hi got %h want 1", hi); end
    endtask

    task automatic test_div_edge;
        int n;
        logic [31:0] hi, lo;
        write_hilo(MDU_MTHI, 32'h1234);
        MDUop = MDU_MFHI; #1;
        checks++; if (MDUout !== 32'h1234) begin errors++; $display("FAIL mthi_latency got %h want 1234", MDUout); end
        MDUop = MDU_NONE;
        run_op(MDU_DIV, 32'd5, 32'd0, n);
        checks++; if (n !== 10) begin errors++; $display("FAIL div0_busy got %0d want 10", n); end
        read_hilo(hi, lo);
        checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL div0_hi got %h want 1234", hi); end
        checks++; if (lo !== 32'd3) begin errors++; $display("FAIL div0_lo got %h want 3", lo); end
        run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
        read_hilo(hi, lo);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL intmin_lo got %h want 80000000", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL intmin_hi got %h want 0", hi); end
    endtask

    task automatic test_reset_abort;
        logic [31:0] hi, lo;
        write_hilo(MDU_MTHI, 32'hAAAA);
        write_hilo(MDU_MTLO, 32'hBBBB);
        start = 1'b1; MDUop = MDU_MULT; srcA = 32'd3; srcB = 32'd4;
        tick();
        start = 1'b0; MDUop = MDU_NONE; srcA = '0; srcB = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b want 0", busy); end
        read_hilo(hi, lo);
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL abort_hilo got %h_%h want 0_0", hi, lo); end
        checks++; if (MDUout !== 32'd0) begin errors++; $display("FAIL abort_mduout got %h want 0", MDUout); end
        repeat (8) tick();
        read_hilo(hi, lo);
        checks++; if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_no_commit got %h_%h busy %0b want 0_0 busy 0", hi, lo, busy);
        end
    endtask

    task automatic test_busy_illegal;
        int n;
        logic [31:0] hi, lo;
        write_hilo(MDU_MTLO, 32'h55);
        write_hilo(MDU_MTHI, 32'h66);
        illegal_hits = 0;
        start = 1'b1; MDUop = MDU_MULT; srcA = 32'd2; srcB = 32'd3;
        tick();
        start = 1'b0; MDUop = MDU_MFHI; srcA = '0; srcB = '0; #1;
        checks++; if (MDUout !== 32'h66) begin errors++; $display("FAIL mfhi_busy got %h want 66", MDUout); end
        start = 1'b1; MDUop = MDU_DIV; srcA = 32'd100; srcB = 32'd7;
        tick();
        start = 1'b0; MDUop = MDU_MTHI; srcA = 32'h999;
        tick();
        MDUop = MDU_NONE; srcA = '0; srcB = '0;
        n = 2;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        checks++; if (n !== 5) begin errors++; $display("FAIL illegal_busy_len got %0d want 5", n); end
        read_hilo(hi, lo);
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL illegal_hi got %h want 0", hi); end
        checks++; if (lo !== 32'd6) begin errors++; $display("FAIL illegal_lo got %h want 6", lo); end
        checks++; if (illegal_hits !== 2) begin errors++; $display("FAIL illegal_flag got %0d want 2", illegal_hits); end
    endtask

    task automatic test_back_to_back;
        int n;
        logic [31:0] hi, lo;
        run_op(MDU_MULT, 32'd2, 32'd3, n);
        run_op(MDU_MULTU, 32'h0001_0000, 32'h0003_0000, n);
        checks++; if (n !== 5) begin errors++; $display("FAIL b2b_busy got %0d want 5", n); end
        read_hilo(hi, lo);
        checks++; if (hi !== 32'd3 || lo !== 32'd0) begin errors++; $display("FAIL b2b_hilo got %h_%h want 3_0", hi, lo); end
        run_op(MDU_DIVU, 32'hFFFF_FFFF, 32'h10, n);
        read_hilo(hi, lo);
        checks++; if (hi !== 32'hF || lo !== 32'h0FFF_FFFF) begin errors++; $display("FAIL b2b_divu got %h_%h want f_0fffffff", hi, lo); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_edge();
        test_reset_abort();
        test_busy_illegal();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
